// File: rtl/morse_serial_receiver.sv
// morse_serial_receiver
//   Receive side of the Morse link. Samples a serial on/off key stream once per
//   unit strobe, measures mark/space run lengths, rebuilds the dot/dash pattern
//   and emits the 5-bit letter index (A=0 .. Z=25).
//
// Ports
//   clock         in   system clock
//   reset_n       in   synchronous active-low reset
//   tick          in   unit strobe, one cycle per Morse unit
//   din           in   serial key bit, sampled only when tick=1
//   letter        out  decoded index 0..25, 5'b11111 on error (holds between pulses)
//   letter_valid  out  one-cycle pulse, letter/letter_err valid
//   letter_err    out  malformed symbol, qualifies letter_valid
//   busy          out  high whenever the receiver is not idle
//   let_cnt       out  (MORSE_RX_STATS_EN) saturating count of emitted letters
//   err_cnt       out  (MORSE_RX_STATS_EN) saturating count of errored letters
//
// Optional feature: define MORSE_RX_STATS_EN to add the let_cnt/err_cnt counters.
//
// Parameters
//   GAP_UNITS  consecutive space units that terminate a letter
//   DASH_MAX   longest mark run accepted as a dash (a run of 1 is a dot)
//   RUN_W      width of the run counters; they saturate at 2^RUN_W-1.
//              GAP_UNITS must fit in RUN_W bits.

module morse_serial_receiver #(
    parameter int GAP_UNITS = 3,
    parameter int DASH_MAX  = 3,
    parameter int RUN_W     = 3
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       din,
    output logic [4:0] letter,
    output logic       letter_valid,
    output logic       letter_err,
`ifdef MORSE_RX_STATS_EN
    output logic [7:0] let_cnt,
    output logic [7:0] err_cnt,
`endif
    output logic       busy
);

    typedef enum logic [1:0] {S_IDLE, S_MARK, S_SPACE} state_t;

    localparam logic [4:0] LET_BAD = 5'b11111;

    state_t           r_state,   w_state_nxt;
    logic [RUN_W-1:0] r_run,     w_run_nxt;
    logic [RUN_W-1:0] r_zcnt,    w_zcnt_nxt;
    logic [2:0]       r_elems,   w_elems_nxt;
    logic [3:0]       r_pattern, w_pattern_nxt;
    logic             r_err,     w_err_nxt;
    logic             w_emit;
    logic             w_elem;
    logic             w_bad_run;
    logic [4:0]       w_lut;

    logic [4:0]       r_letter;
    logic             r_valid;
    logic             r_lerr;

    // Reverse lookup of (element count, pattern). The pattern is built by left
    // shifts from zero, so the unused upper bits are always 0.
    function automatic logic [4:0] f_lookup(input logic [2:0] n, input logic [3:0] p);
        logic [4:0] v;
        v = LET_BAD;
        case ({n, p})
            {3'd1, 4'b0000}: v = 5'd4;   // E
            {3'd1, 4'b0001}: v = 5'd19;  // T
            {3'd2, 4'b0000}: v = 5'd8;   // I
            {3'd2, 4'b0001}: v = 5'd0;   // A
            {3'd2, 4'b0010}: v = 5'd13;  // N
            {3'd2, 4'b0011}: v = 5'd12;  // M
            {3'd3, 4'b0000}: v = 5'd18;  // S
            {3'd3, 4'b0001}: v = 5'd20;  // U
            {3'd3, 4'b0010}: v = 5'd17;  // R
            {3'd3, 4'b0011}: v = 5'd22;  // W
            {3'd3, 4'b0100}: v = 5'd3;   // D
            {3'd3, 4'b0101}: v = 5'd10;  // K
            {3'd3, 4'b0110}: v = 5'd6;   // G
            {3'd3, 4'b0111}: v = 5'd14;  // O
            {3'd4, 4'b0000}: v = 5'd7;   // H
            {3'd4, 4'b0001}: v = 5'd21;  // V
            {3'd4, 4'b0010}: v = 5'd5;   // F
            {3'd4, 4'b0100}: v = 5'd11;  // L
            {3'd4, 4'b0110}: v = 5'd15;  // P
            {3'd4, 4'b0111}: v = 5'd9;   // J
            {3'd4, 4'b1000}: v = 5'd1;   // B
            {3'd4, 4'b1001}: v = 5'd23;  // X
            {3'd4, 4'b1010}: v = 5'd2;   // C
            {3'd4, 4'b1011}: v = 5'd24;  // Y
            {3'd4, 4'b1100}: v = 5'd25;  // Z
            {3'd4, 4'b1101}: v = 5'd16;  // Q
            default:         v = LET_BAD;
        endcase
        return v;
    endfunction

    // Mark classification: 1 unit = dot, 2..DASH_MAX = dash, longer = error.
    assign w_elem    = (r_run != RUN_W'(1));
    assign w_bad_run = (32'(r_run) > DASH_MAX) || (DASH_MAX < 2 && r_run != RUN_W'(1));
    assign w_lut     = r_err ? LET_BAD : f_lookup(r_elems, r_pattern);

    always_comb begin
        w_state_nxt   = r_state;
        w_run_nxt     = r_run;
        w_zcnt_nxt    = r_zcnt;
        w_elems_nxt   = r_elems;
        w_pattern_nxt = r_pattern;
        w_err_nxt     = r_err;
        w_emit        = 1'b0;
        if (tick) begin
            case (r_state)
                S_IDLE: begin
                    if (din) begin
                        w_state_nxt   = S_MARK;
                        w_run_nxt     = RUN_W'(1);
                        w_elems_nxt   = 3'd0;
                        w_pattern_nxt = 4'd0;
                        w_err_nxt     = 1'b0;
                    end
                end
                S_MARK: begin
                    if (din) begin
                        if (!(&r_run))
                            w_run_nxt = r_run + RUN_W'(1);
                    end else begin
                        w_err_nxt = r_err | w_bad_run;
                        if (r_elems == 3'd4) begin
                            w_err_nxt = 1'b1;  // fifth element: no letter that long
                        end else begin
                            w_pattern_nxt = {r_pattern[2:0], w_elem};
                            w_elems_nxt   = r_elems + 3'd1;
                        end
                        w_state_nxt = S_SPACE;
                        w_zcnt_nxt  = RUN_W'(1);
                    end
                end
                S_SPACE: begin
                    if (din) begin
                        w_state_nxt = S_MARK;
                        w_run_nxt   = RUN_W'(1);
                    end else if (32'(r_zcnt) + 1 >= GAP_UNITS) begin
                        w_state_nxt = S_IDLE;
                        w_emit      = 1'b1;
                    end else begin
                        w_zcnt_nxt = r_zcnt + RUN_W'(1);
                    end
                end
                default: w_state_nxt = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_run     <= '0;
            r_zcnt    <= '0;
            r_elems   <= '0;
            r_pattern <= '0;
            r_err     <= 1'b0;
            r_letter  <= '0;
            r_valid   <= 1'b0;
            r_lerr    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_run     <= w_run_nxt;
            r_zcnt    <= w_zcnt_nxt;
            r_elems   <= w_elems_nxt;
            r_pattern <= w_pattern_nxt;
            r_err     <= w_err_nxt;
            r_valid   <= w_emit;  // single-cycle pulse, independent of tick
            if (w_emit) begin
                r_letter <= w_lut;
                r_lerr   <= (w_lut == LET_BAD);
            end
        end
    end

    assign letter       = r_letter;
    assign letter_valid = r_valid;
    assign letter_err   = r_lerr;
    assign busy         = (r_state != S_IDLE);

`ifdef MORSE_RX_STATS_EN
    logic [7:0] r_let_cnt;
    logic [7:0] r_err_cnt;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            r_let_cnt <= '0;
            r_err_cnt <= '0;
        end else if (r_valid) begin
            if (r_let_cnt != 8'hff)
                r_let_cnt <= r_let_cnt + 8'd1;
            if (r_lerr && r_err_cnt != 8'hff)
                r_err_cnt <= r_err_cnt + 8'd1;
        end
    end

    assign let_cnt = r_let_cnt;
    assign err_cnt = r_err_cnt;
`endif

endmodule

// File: tb/tb_morse_serial_receiver.sv
// Directed bench for morse_serial_receiver: one unit strobe every 4 clocks,
// letters sent as key streams, decoded pulses collected at the falling edge.

module tb_morse_serial_receiver;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       tick;
    logic       din;
    logic [4:0] letter;
    logic       letter_valid;
    logic       letter_err;
    logic       busy;
`ifdef MORSE_RX_STATS_EN
    logic [7:0] let_cnt;
    logic [7:0] err_cnt;
`endif

    int total = 0;
    int bad   = 0;

    int q_let[$];
    int q_err[$];

    // Morse table in index order A..Z: element count and pattern (dash=1, first in MSB)
    int code_len[26] = '{2,4,4,3,1,4,3,4,2,4,3,4,2,2,3,4,4,3,3,1,3,4,3,4,4,4};
    int code_pat[26] = '{1,8,10,4,0,2,6,0,0,7,5,4,3,2,7,6,13,2,0,1,1,1,3,9,11,12};

    morse_serial_receiver dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .tick         (tick),
        .din          (din),
        .letter       (letter),
        .letter_valid (letter_valid),
        .letter_err   (letter_err),
`ifdef MORSE_RX_STATS_EN
        .let_cnt      (let_cnt),
        .err_cnt      (err_cnt),
`endif
        .busy         (busy)
    );

    always #5 clock = ~clock;

    always @(negedge clock) begin
        if (letter_valid) begin
            q_let.push_back(int'(letter));
            q_err.push_back(int'(letter_err));
        end
    end

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One strobed unit; returns 1 time unit after the edge that consumed it.
    task automatic unit(input logic b);
        din  = b;
        tick = 1'b1;
        @(posedge clock); #1;
        tick = 1'b0;
    endtask

    task automatic send(input logic b);
        unit(b);
        repeat (3) begin @(posedge clock); #1; end
    endtask

    task automatic send_vec(input logic [15:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send(v[i]);
    endtask

    task automatic send_code(input int idx);
        for (int i = code_len[idx] - 1; i >= 0; i--) begin
            if (((code_pat[idx] >> i) & 1) != 0) begin
                send(1'b1); send(1'b1); send(1'b1);
            end else begin
                send(1'b1);
            end
            send(1'b0);
        end
        send(1'b0); send(1'b0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        @(posedge clock); #1;
        reset_n = 1'b1;
    endtask

    initial begin
        reset_n = 1'b0;
        tick    = 1'b0;
        din     = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        chk("rst_letter", int'(letter), 0);
        chk("rst_valid",  int'(letter_valid), 0);
        chk("rst_err",    int'(letter_err), 0);
        chk("rst_busy",   int'(busy), 0);
        reset_n = 1'b1;

        // E: 1 then three zero units; pulse right after the third zero tick
        q_let.delete(); q_err.delete();
        send(1'b1); send(1'b0); send(1'b0);
        unit(1'b0);
        chk("e_valid", int'(letter_valid), 1);
        chk("e_letter", int'(letter), 4);
        chk("e_err", int'(letter_err), 0);
        @(posedge clock); #1;
        chk("e_valid_clr", int'(letter_valid), 0);
        repeat (2) begin @(posedge clock); #1; end
        for (int i = 0; i < 10; i++) send(1'b0);
        chk("e_pulses", q_let.size(), 1);
        chk("e_busy", int'(busy), 0);
        chk("e_hold", int'(letter), 4);

        // J then Q, each padded to a full letter gap
        q_let.delete(); q_err.delete();
        send_vec(16'b10111011101110, 14); send(1'b0); send(1'b0);
        send_vec(16'b11101110101110, 14); send(1'b0); send(1'b0);
        chk("jq_pulses", q_let.size(), 2);
        if (q_let.size() == 2) begin
            chk("jq_j", q_let[0], 9);
            chk("jq_q", q_let[1], 16);
            chk("jq_err", q_err[0] + q_err[1], 0);
        end

        // Full alphabet sweep from a fresh reset
        do_reset();
        q_let.delete(); q_err.delete();
        for (int i = 0; i < 26; i++) send_code(i);
        chk("az_pulses", q_let.size(), 26);
        if (q_let.size() == 26) begin
            for (int i = 0; i < 26; i++) begin
                chk($sformatf("az_letter%0d", i), q_let[i], i);
                chk($sformatf("az_err%0d", i), q_err[i], 0);
            end
        end
`ifdef MORSE_RX_STATS_EN
        chk("stats_let", int'(let_cnt), 26);
        chk("stats_err", int'(err_cnt), 0);
`endif

        // Over-long mark
        q_let.delete(); q_err.delete();
        send_vec(16'b11111000, 8);
        chk("long_pulses", q_let.size(), 1);
        if (q_let.size() == 1) begin
            chk("long_letter", q_let[0], 31);
            chk("long_err", q_err[0], 1);
        end

        // Five dots overflow the pattern
        q_let.delete(); q_err.delete();
        send_vec(16'b1010101010, 10); send_vec(16'b000, 3);
        chk("ovf_pulses", q_let.size(), 1);
        if (q_let.size() == 1) begin
            chk("ovf_letter", q_let[0], 31);
            chk("ovf_err", q_err[0], 1);
        end
`ifdef MORSE_RX_STATS_EN
        chk("stats_let2", int'(let_cnt), 28);
        chk("stats_err2", int'(err_cnt), 2);
`endif

        // Reset midway through B discards it; T follows cleanly
        q_let.delete(); q_err.delete();
        send_vec(16'b1110, 4);
        chk("midb_busy", int'(busy), 1);
        do_reset();
        chk("midb_busy_rst", int'(busy), 0);
        chk("midb_letter_rst", int'(letter), 0);
        send_vec(16'b111000, 6);
        chk("t_pulses", q_let.size(), 1);
        if (q_let.size() == 1) begin
            chk("t_letter", q_let[0], 19);
            chk("t_err", q_err[0], 0);
        end

        // No strobe: din toggling must not move the receiver
        q_let.delete(); q_err.delete();
        send(1'b1);
        for (int i = 0; i < 20; i++) begin
            din = ~din;
            @(posedge clock); #1;
        end
        chk("notick_busy", int'(busy), 1);
        chk("notick_pulses", q_let.size(), 0);
        send(1'b0); send(1'b0); send(1'b0);
        chk("notick_after_pulses", q_let.size(), 1);
        if (q_let.size() == 1)
            chk("notick_letter", q_let[0], 4);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/morse_serial_receiver.md
Name: morse_serial_receiver

Overview:
- Downstream stage of the Morse encoder/shifter. Consumes its serial on/off key stream, one bit per Morse unit.
- Measures mark and space run lengths and rebuilds the dot/dash pattern.
- Emits the 5-bit letter index, A=0 through Z=25, i.e. the same index space fed to the encoder.
- Closes the loop for self-check and for the receive side of the Enigma link.

Parameters:
- GAP_UNITS, default 3: consecutive space units that terminate a letter.
- DASH_MAX, default 3: longest mark run (units) accepted as a dash. A run of 2..DASH_MAX is a dash; a run of 1 is a dot.
- RUN_W, default 3: width of the run counters. They saturate at 2^RUN_W-1.

Ports:
- clock  in  1  system clock
- reset_n  in  1  synchronous, active-low reset; clock clock
- tick  in  1  unit strobe, one cycle high per Morse unit (same rate as the encoder's shift enable)
- din  in  1  serial key bit, sampled only when tick=1
- letter  out  5  decoded index 0..25; 5'b11111 on error
- letter_valid  out  1  one-cycle pulse, letter and letter_err valid
- letter_err  out  1  qualifies letter_valid; malformed symbol
- busy  out  1  high whenever state != IDLE

Behaviour:
- Reset: state=IDLE, letter=0, letter_valid=0, letter_err=0, busy=0. Pattern, element count, run counters and error latch are cleared.
- Reset wins over tick. Reset mid-letter discards the partial symbol and emits nothing.
- All state changes happen only on clock edges with tick=1, except the letter_valid clear. letter_valid is high for exactly one clock and then deasserts regardless of tick.
- IDLE, din=0: stay.
- IDLE, din=1: go to MARK, run=1, elems=0, pattern=0, err=0.
- MARK, din=1: run++ (saturating).
- MARK, din=0: classify the run.
  - run=1: dot (0).
  - 2<=run<=DASH_MAX: dash (1).
  - Otherwise: set err.
  - If elems==4 already, set err (overflow). Else pattern={pattern[2:0],elem} and elems++.
  - Go to SPACE, zcnt=1.
- SPACE, din=1: go to MARK, run=1 (intra-letter gap). This only happens while zcnt<GAP_UNITS.
- SPACE, din=0: zcnt++. On the tick where zcnt reaches GAP_UNITS, go to IDLE and schedule emission.
- Emission:
  - letter_valid rises on the clock edge after the terminating tick (1-cycle latency from that tick).
  - letter comes from a reverse lookup of (elems, pattern), dot=0 and dash=1, first element in the MSB of the used bits.
  - Lookup entries: A 2'b01, B 1000, C 1010, D 100, E 0, F 0010, G 110, H 0000, I 00, J 0111, K 101, L 0100, M 11, N 10, O 111, P 0110, Q 1101, R 010, S 000, T 1, U 001, V 0001, W 011, X 1001, Y 1011, Z 1100.
  - An unmatched 4-element pattern (0011, 0101, 1110, 1111) or a set err gives letter=5'b11111 and letter_err=1.
- A stuck-high din saturates run. Nothing is emitted until din falls; the letter then ends in error.
- Trailing zeros after a letter (the encoder pads to 14 bits) are absorbed in IDLE with no output.
- letter holds its last value between pulses. letter_err is meaningful only with letter_valid.

Optional Feature:
- Macro MORSE_RX_STATS_EN.
- When defined: add output ports let_cnt[7:0] and err_cnt[7:0], both reset to 0.
  - let_cnt increments on every letter_valid.
  - err_cnt increments on letter_valid with letter_err.
  - Both saturate at 255.
- When undefined: the ports and counters are absent. Decode behaviour is identical.

Test Plan:
- Encoder LUT stream for E (10000000000000), tick every 4 clocks → letter=4, letter_err=0. letter_valid pulses once, 1 clock after the 3rd zero tick. busy low afterwards.
- Stream for J (10111011101110) then for Q (11101110101110) back-to-back → letter=9 then letter=16, two pulses, no errors.
- All 26 encoder patterns in sequence, each followed by zero padding → letters 0..25 in order. Requires exactly 26 pulses and err=0; with MORSE_RX_STATS_EN, let_cnt=26 and err_cnt=0.
- Mark of 5 units (11111 then 000) → letter_valid with letter=5'b11111 and letter_err=1.
- Five dots (1010101010 then 000) → overflow error, letter=31, letter_err=1.
- Assert reset_n=0 for one clock midway through B (after 1110) → no pulse. Then send T (111000) → letter=19.
- Hold tick=0 with din toggling for 20 clocks → no state change, busy unchanged.
